// File: rtl/ram_fill_ctrl.sv
// ram_fill_ctrl: collects RAM_SIZE stream words into a staging buffer, pulses the
// bank load strobe once per frame and holds the frame valid until the consumer acks.
// Optional feature macro RAM_FILL_AUTO_RESTART_EN: ack in FULL re-enters FILL without start.
module ram_fill_ctrl #(
    parameter int BIT_SIZE = 16,
    parameter int RAM_SIZE = 8,
    parameter int CNT_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BIT_SIZE-1:0]          in_data,
    output logic                         ram_ld,
    output logic [BIT_SIZE*RAM_SIZE-1:0] ram_par_in,
    output logic                         frame_valid,
    input  logic                         ack,
    output logic                         busy,
    output logic [CNT_W-1:0]             word_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        LOAD = 2'd2,
        FULL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RAM_SIZE - 1);

    state_t state;

    // FULL exit target on ack: with auto-restart every ack re-enters FILL.
    logic restart;
`ifdef RAM_FILL_AUTO_RESTART_EN
    assign restart = 1'b1;
`else
    assign restart = start;
`endif

    // Registered FSM; every output is a register decoded from the next state.
    // in_ready depends on state only, so no combinational path from in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_cnt    <= '0;
            ram_par_in  <= '0;
            ram_ld      <= 1'b0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        word_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                FILL: begin
                    // abort wins over a simultaneous accept; the word is dropped
                    if (abort) begin
                        state    <= IDLE;
                        word_cnt <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (in_valid) begin
                        ram_par_in[word_cnt*BIT_SIZE +: BIT_SIZE] <= in_data;
                        if (word_cnt == LAST_IDX) begin
                            state    <= LOAD;
                            word_cnt <= '0;
                            in_ready <= 1'b0;
                            ram_ld   <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end

                LOAD: begin
                    state       <= FULL;
                    ram_ld      <= 1'b0;
                    frame_valid <= 1'b1;
                end

                FULL: begin
                    // staging buffer is left untouched here so the bank copy stays coherent
                    if (ack) begin
                        frame_valid <= 1'b0;
                        if (restart) begin
                            state    <= FILL;
                            word_cnt <= '0;
                            in_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    word_cnt    <= '0;
                    ram_ld      <= 1'b0;
                    frame_valid <= 1'b0;
                    busy        <= 1'b0;
                    in_ready    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fill_ctrl.sv
// tb_ram_fill_ctrl: self-checking bench for ram_fill_ctrl.
// Expected frames are queued when a fill is driven and compared on each ram_ld pulse.
// Build with +define+RAM_FILL_AUTO_RESTART_EN to exercise the auto-restart variant.
module tb_ram_fill_ctrl;

    localparam int BW = 16;
    localparam int RS = 8;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [BW-1:0]     in_data = '0;
    logic              ack = 1'b0;
    logic              in_ready;
    logic              ram_ld;
    logic [BW*RS-1:0]  ram_par_in;
    logic              frame_valid;
    logic              busy;
    logic [CW-1:0]     word_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int ld_count = 0;
    int rdy_cycles = 0;
    logic [BW*RS-1:0] sb_q[$];

    ram_fill_ctrl #(.BIT_SIZE(BW), .RAM_SIZE(RS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ram_ld(ram_ld), .ram_par_in(ram_par_in), .frame_valid(frame_valid),
        .ack(ack), .busy(busy), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW*RS-1:0] obs, input logic [BW*RS-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [BW*RS-1:0] mk_frame(input logic [BW-1:0] base);
        logic [BW*RS-1:0] f;
        f = '0;
        for (int i = 0; i < RS; i++) f[i*BW +: BW] = base + BW'(i);
        return f;
    endfunction

    // scoreboard: every load strobe must match the oldest queued frame
    always @(negedge clk) begin
        if (ram_ld) begin
            ld_count++;
            if (sb_q.size() == 0) check("ld_unexpected", 1, 0);
            else check("frame_data", ram_par_in, sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_ram_ld"}, ram_ld, 0);
        check({tag, "_frame_valid"}, frame_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_word_cnt"}, word_cnt, 0);
        check({tag, "_par_in"}, ram_par_in, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_ready", in_ready, 1);
        check("start_busy", busy, 1);
        check("start_word_cnt", word_cnt, 0);
    endtask

    task automatic push_word(input logic [BW-1:0] d);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check("accept_rdy", in_ready, 1);
        if (in_ready) rdy_cycles++;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [BW-1:0] base, input bit gaps);
        int ld0;
        ld0 = ld_count;
        sb_q.push_back(mk_frame(base));
        for (int i = 0; i < RS; i++) begin
            if (gaps && i > 0) begin
                tick();
                tick();
                check("gap_word_cnt", word_cnt, i);
            end
            push_word(base + BW'(i));
            if (i < RS - 1) check("word_cnt", word_cnt, i + 1);
        end
        check("load_ram_ld", ram_ld, 1);
        check("load_frame_valid", frame_valid, 0);
        check("load_in_ready", in_ready, 0);
        check("load_word_cnt", word_cnt, 0);
        tick();
        check("full_ram_ld", ram_ld, 0);
        check("full_frame_valid", frame_valid, 1);
        check("full_busy", busy, 1);
        check("ld_once", ld_count - ld0, 1);
    endtask

    task automatic ack_to_idle();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_frame_valid", frame_valid, 0);
`ifdef RAM_FILL_AUTO_RESTART_EN
        check("auto_in_ready", in_ready, 1);
        check("auto_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`else
        check("ack_in_ready", in_ready, 0);
`endif
        check("ack_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ld0;
        logic [BW*RS-1:0] snap;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_vals("rst");

        // basic fill with continuous valid
        do_start();
        rdy_cycles = 0;
        send_frame(16'h0001, 1'b0);
        check("rdy_cycles", rdy_cycles, 8);
        check("basic_par_in", ram_par_in, mk_frame(16'h0001));
`ifdef RAM_FILL_AUTO_RESTART_EN
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("auto_restart_rdy", in_ready, 1);
        send_frame(16'h0010, 1'b0);
`endif
        ack_to_idle();

        // backpressure: valid pattern 1,0,0,1,...
        do_start();
        send_frame(16'h00A0, 1'b1);
        check("gap_par_in", ram_par_in, mk_frame(16'h00A0));
        ack_to_idle();

        // abort beats a simultaneous accept
        ld0 = ld_count;
        do_start();
        for (int i = 0; i < 3; i++) push_word(16'h00C0 + BW'(i));
        check("pre_abort_cnt", word_cnt, 3);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_word_cnt", word_cnt, 0);
        check("abort_not_stored", ram_par_in[3*BW +: BW], 16'h00A3);
        check("abort_no_ld", ld_count - ld0, 0);
        do_start();
        send_frame(16'h0050, 1'b0);
        ack_to_idle();

        // hold: inputs ignored in FULL until ack
        do_start();
        send_frame(16'h0030, 1'b0);
        snap = mk_frame(16'h0030);
        ld0 = ld_count;
        in_valid = 1'b1;
        start    = 1'b1;
        in_data  = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_in_ready", in_ready, 0);
            check("hold_par_in", ram_par_in, snap);
            check("hold_frame_valid", frame_valid, 1);
        end
        check("hold_no_ld", ld_count - ld0, 0);
        in_valid = 1'b0;
        ack = 1'b1;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        check("ackstart_in_ready", in_ready, 1);
        check("ackstart_fv", frame_valid, 0);
        check("ackstart_par_in", ram_par_in, snap);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ackstart_abort_busy", busy, 0);

        // reset in the middle of a fill
        do_start();
        for (int i = 0; i < 5; i++) push_word(16'h0070 + BW'(i));
        check("mid_word_cnt", word_cnt, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("rst_mid");

        // reset coinciding with the last accept drops the pending load
        ld0 = ld_count;
        do_start();
        for (int i = 0; i < RS - 1; i++) push_word(16'h0090 + BW'(i));
        in_valid = 1'b1;
        in_data  = 16'h0097;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check_reset_vals("rst_load");
        tick();
        check("rst_load_no_ld", ram_ld, 0);
        check("rst_load_ld_cnt", ld_count - ld0, 0);

        // fresh frame after reset still loads correctly
        do_start();
        send_frame(16'h0100, 1'b0);
        ack_to_idle();

        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
